// File: rtl/dmem_bus_bridge.sv
// MEM-stage RAM port to request/grant/response data bus bridge.
// One outstanding access; the pipeline is stalled until the response or timeout.
module dmem_bus_bridge #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ren_i,
  input  logic        ram_wen_i,
  input  logic [63:0] ram_addr_i,
  input  logic [7:0]  ram_byte_en_i,
  input  logic [63:0] ram_wdata_i,
  output logic [63:0] ram_rdata_o,
  output logic        mem_stall_o,
  output logic        ld_bus_err_o,
  output logic        st_bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [63:0] bus_addr_o,
  output logic [7:0]  bus_be_o,
  output logic [63:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [63:0] bus_rdata_i,
  input  logic        bus_err_i
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          state;
  logic [63:0]     rdata_q;
  logic            err_q;
  logic            we_q;
  logic [CW-1:0]   cnt;
  logic            acc;
  logic            gnt_now;

  assign acc     = ram_ren_i | ram_wen_i;
  assign gnt_now = bus_req_o & bus_gnt_i;

  // Payload is a pass-through; the MEM stage holds it stable until grant.
  assign bus_req_o   = ((state == IDLE) && acc) || (state == REQ);
  assign bus_we_o    = ram_wen_i;
  assign bus_addr_o  = ram_addr_i & ~64'h7;
  assign bus_be_o    = ram_wen_i ? ram_byte_en_i : 8'hFF;
  assign bus_wdata_o = ram_wdata_i;

  assign mem_stall_o  = ((state == IDLE) && acc) || (state == REQ) || (state == RESP);
  assign ram_rdata_o  = rdata_q;
  assign ld_bus_err_o = (state == DONE) && err_q && !we_q;
  assign st_bus_err_o = (state == DONE) && err_q && we_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, REQ: begin
          if (gnt_now) begin
            state <= RESP;
            cnt   <= '0;
            we_q  <= ram_wen_i;
          end else if (state == IDLE && acc) begin
            state <= REQ;
          end
        end
        RESP: begin
          if (bus_rvalid_i) begin
            rdata_q <= bus_rdata_i;
            err_q   <= bus_err_i;
            state   <= DONE;
          end else if (cnt == CW'(TIMEOUT)) begin
            // Timed out: flag an error, leave the read data register alone.
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: expectations queued at drive time,
// popped when the DUT releases the stall on a held access.
module tb_dmem_bus_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_ren_i, ram_wen_i;
  logic [63:0] ram_addr_i, ram_wdata_i;
  logic [7:0]  ram_byte_en_i;
  logic [63:0] ram_rdata_o;
  logic        mem_stall_o, ld_bus_err_o, st_bus_err_o;
  logic        bus_req_o, bus_we_o;
  logic [63:0] bus_addr_o, bus_wdata_o;
  logic [7:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic [63:0] bus_rdata_i;

  dmem_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ram_ren_i(ram_ren_i), .ram_wen_i(ram_wen_i), .ram_addr_i(ram_addr_i),
    .ram_byte_en_i(ram_byte_en_i), .ram_wdata_i(ram_wdata_i),
    .ram_rdata_o(ram_rdata_o), .mem_stall_o(mem_stall_o),
    .ld_bus_err_o(ld_bus_err_o), .st_bus_err_o(st_bus_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        ld;
    logic        st;
    int          stall;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_bad = 0;
  int          stall_cnt = 0;
  logic [63:0] model_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Completion monitor: a held access with stall low is the DONE cycle.
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0;
    end else if (ram_ren_i || ram_wen_i) begin
      if (mem_stall_o) begin
        stall_cnt++;
        chk("err_quiet", {62'd0, ld_bus_err_o, st_bus_err_o}, 64'd0);
      end else begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("stall_cycles", 64'(stall_cnt), 64'(mon_e.stall));
          chk("rdata", ram_rdata_o, mon_e.rdata);
          chk("ld_err", {63'd0, ld_bus_err_o}, {63'd0, mon_e.ld});
          chk("st_err", {63'd0, st_bus_err_o}, {63'd0, mon_e.st});
        end
        stall_cnt = 0;
      end
    end
  end

  // gdly: cycles before grant; rdly: RESP cycle (1-based) carrying rvalid; to: no response.
  task automatic do_acc(input logic ren, input logic wen, input logic [63:0] addr,
                        input logic [7:0] be, input logic [63:0] wd, input int gdly,
                        input int rdly, input logic [63:0] rd, input logic er, input logic to);
    exp_t e;
    logic [7:0] exp_be;
    exp_be = wen ? be : 8'hFF;
    if (!to) model_rdata = rd;
    e.rdata = model_rdata;
    e.ld    = (to || er) && !wen;
    e.st    = (to || er) && wen;
    e.stall = to ? (gdly + 1 + TO + 1) : (gdly + 1 + rdly);
    sb.push_back(e);
    ram_ren_i = ren; ram_wen_i = wen; ram_addr_i = addr;
    ram_byte_en_i = be; ram_wdata_i = wd;
    for (int i = 0; i <= gdly; i++) begin
      bus_gnt_i = (i == gdly);
      @(negedge clk);
      chk("req", {63'd0, bus_req_o}, 64'd1);
      chk("we", {63'd0, bus_we_o}, {63'd0, wen});
      chk("addr", bus_addr_o, addr & ~64'h7);
      chk("be", {56'd0, bus_be_o}, {56'd0, exp_be});
      chk("wdata", bus_wdata_o, wd);
      @(posedge clk); #1;
    end
    bus_gnt_i = 1'b0;
    if (to) begin
      repeat (TO + 1) begin @(posedge clk); #1; end
    end else begin
      for (int j = 1; j <= rdly; j++) begin
        bus_rvalid_i = (j == rdly);
        bus_rdata_i  = (j == rdly) ? rd : 64'hBAD0_BAD0_BAD0_BAD0;
        bus_err_i    = (j == rdly) ? er : 1'b1;
        @(negedge clk);
        chk("req_low_resp", {63'd0, bus_req_o}, 64'd0);
        @(posedge clk); #1;
      end
      bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    end
    @(posedge clk); #1;
    ram_ren_i = 1'b0; ram_wen_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ram_ren_i = 0; ram_wen_i = 0; ram_addr_i = '0; ram_byte_en_i = '0; ram_wdata_i = '0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_err_i = 0; bus_rdata_i = '0;
    #1;
    chk("rst_stall", {63'd0, mem_stall_o}, 64'd0);
    chk("rst_req", {63'd0, bus_req_o}, 64'd0);
    chk("rst_rdata", ram_rdata_o, 64'd0);
    chk("rst_err", {62'd0, ld_bus_err_o, st_bus_err_o}, 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    do_acc(1, 0, 64'h1008, 8'h00, 64'h0, 0, 1, 64'h1122334455667788, 0, 0);
    do_acc(0, 1, 64'h2000, 8'h0C, {4{16'hBEEF}}, 3, 2, 64'h0, 0, 0);
    do_acc(1, 0, 64'h3010, 8'h00, 64'h0, 1, 1, 64'hA5A5_5A5A_0F0F_F0F0, 1, 0);
    do_acc(0, 1, 64'h3018, 8'hF0, 64'h0123_4567_89AB_CDEF, 0, 3, 64'h7777_0000_7777_0000, 1, 0);
    do_acc(1, 0, 64'h4000, 8'h00, 64'h0, 0, 1, 64'h0, 0, 1);
    // Late response in IDLE must not disturb the read data register.
    bus_rvalid_i = 1; bus_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD; bus_err_i = 1;
    @(posedge clk); #1;
    bus_rvalid_i = 0; bus_err_i = 0;
    @(negedge clk);
    chk("late_rvalid", ram_rdata_o, model_rdata);
    chk("late_stall", {63'd0, mem_stall_o}, 64'd0);
    @(posedge clk); #1;
    do_acc(1, 1, 64'h5008, 8'h81, 64'hCAFE_F00D_CAFE_F00D, 0, 1, 64'h5555, 0, 0);
    for (int k = 0; k < 4; k++)
      do_acc(k[0], !k[0], {$urandom, $urandom}, 8'($urandom), {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(1, TO)),
             {$urandom, $urandom}, 1'($urandom_range(0, 1)), 0);

    // Reset while in RESP: outputs clear at once, late rvalid dropped.
    ram_ren_i = 1; ram_addr_i = 64'h40; bus_gnt_i = 1;
    @(posedge clk); #1;
    bus_gnt_i = 0;
    #2 rst = 1'b1; ram_ren_i = 0;
    #1;
    model_rdata = '0;
    chk("arst_stall", {63'd0, mem_stall_o}, 64'd0);
    chk("arst_req", {63'd0, bus_req_o}, 64'd0);
    chk("arst_rdata", ram_rdata_o, 64'd0);
    chk("arst_err", {62'd0, ld_bus_err_o, st_bus_err_o}, 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    bus_rvalid_i = 1; bus_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    bus_rvalid_i = 0;
    @(negedge clk);
    chk("arst_drop", ram_rdata_o, 64'd0);
    @(posedge clk); #1;
    do_acc(1, 0, 64'h6000, 8'h00, 64'h0, 1, 2, 64'h0BAD_C0DE_1234_5678, 0, 0);

    repeat (3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
